// File: rtl/csr_access_sequencer_if.sv
// csr_access_sequencer_if
// Groups the signals between the CSR access sequencer and the blocks around it:
// the pipeline request/response channel, the trap-unit write channel and the
// CSR file strobe bus.
// Modport "slave" is the sequencer's own view. It accepts pipeline and trap
// requests and drives the CSR file and the response.
// Modport "master" is the surrounding environment's view. That is the pipeline,
// the trap unit and the CSR file together.

interface csr_access_sequencer_if #(
  parameter int XLEN = 32
);

  // Pipeline request channel
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic            req_imm;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_rs1_value;
  logic [4:0]      req_zimm;
  logic            req_rd_zero;

  // Trap-unit write channel
  logic            trap_valid;
  logic            trap_ready;
  logic [11:0]     trap_addr;
  logic [XLEN-1:0] trap_wdata;

  // CSR file strobe bus
  logic [11:0]     csr_addr;
  logic            csr_rd_en;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            csr_wr_en;
  logic [XLEN-1:0] csr_wdata;

  // Pipeline response channel
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  modport slave (
    input  req_valid, req_op, req_imm, req_addr, req_rs1_value, req_zimm, req_rd_zero,
    output req_ready,
    input  trap_valid, trap_addr, trap_wdata,
    output trap_ready,
    output csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
    input  csr_rdata, csr_illegal,
    output rsp_valid, rsp_rdata, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_imm, req_addr, req_rs1_value, req_zimm, req_rd_zero,
    input  req_ready,
    output trap_valid, trap_addr, trap_wdata,
    input  trap_ready,
    input  csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
    output csr_rdata, csr_illegal,
    input  rsp_valid, rsp_rdata, rsp_illegal,
    output rsp_ready
  );

endinterface

// File: rtl/csr_access_sequencer.sv
// csr_access_sequencer
// This block is the only master of the CSR file's read and write strobes.
// It serves two clients: the instruction pipeline and the trap unit.
// Pipeline requests (CSRRW/CSRRS/CSRRC in register and immediate forms) run
// as a fixed sequence: READ, then WRITE, then RESP.
// Trap-unit requests are single-cycle writes.
// The architectural write-suppression rules are applied in the WRITE phase.
// The pipeline gets back the old CSR value, or an illegal-instruction flag.
//
// Optional feature macro: CSR_RO_CHECK_EN
//   When defined, addresses with addr[11:10] == 2'b11 are read-only here.
//   Any access to them that would write is turned into an illegal
//   instruction, and the write is suppressed.
//   When undefined, read-only enforcement is left to csr_illegal from the
//   CSR file.

module csr_access_sequencer #(
  parameter int XLEN = 32
) (
  input logic                 clock,
  input logic                 reset_n,
  csr_access_sequencer_if.slave bus
);

  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    TRAP  = 3'd4
  } state_t;

  state_t          state_q, state_d;

  // Request fields captured at handshake; the pipeline may change them afterwards
  logic [1:0]      op_q, op_d;
  logic            imm_q, imm_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [4:0]      zimm_q, zimm_d;
  logic            rd_zero_q, rd_zero_d;

  // Trap write captured at handshake
  logic [11:0]     trap_addr_q, trap_addr_d;
  logic [XLEN-1:0] trap_wdata_q, trap_wdata_d;

  // Old CSR value and accumulated illegal flag for the access in flight
  logic [XLEN-1:0] old_q, old_d;
  logic            ill_q, ill_d;

  // Derived operand and write-decision terms
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_value;
  logic            rd_suppress;
  logic            would_write;
  logic            ro_violation;
  logic            write_allowed;

  // Bus outputs, decoded from state
  logic            req_ready;
  logic            trap_ready;
  logic [11:0]     csr_addr;
  logic            csr_rd_en;
  logic            csr_wr_en;
  logic [XLEN-1:0] csr_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  // Operand selection and the read/write suppression decisions for the captured request
  always_comb begin
    src           = '0;
    new_value     = '0;
    rd_suppress   = 1'b0;
    would_write   = 1'b0;
    ro_violation  = 1'b0;
    write_allowed = 1'b0;

    // Immediate form zero-extends the 5-bit zimm field
    src = imm_q ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;

    // CSRRW with rd == x0 must not read, so that read side effects are avoided
    rd_suppress = (op_q == OP_RW) && rd_zero_q;

    // RS/RC only write when the source field is nonzero.
    // For the register form, this tests the rs1 index, not the rs1 value.
    would_write = (op_q == OP_RW) || (zimm_q != 5'd0);

    case (op_q)
      OP_RW:   new_value = src;
      OP_RS:   new_value = old_q | src;
      OP_RC:   new_value = old_q & ~src;
      default: new_value = '0;
    endcase

`ifdef CSR_RO_CHECK_EN
    ro_violation = would_write && (addr_q[11:10] == 2'b11);
`else
    ro_violation = 1'b0;
`endif

    write_allowed = !ill_q && would_write && !ro_violation;
  end

  // Next-state, field capture and bus-output decode for the access sequence
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    imm_d        = imm_q;
    addr_d       = addr_q;
    rs1_d        = rs1_q;
    zimm_d       = zimm_q;
    rd_zero_d    = rd_zero_q;
    trap_addr_d  = trap_addr_q;
    trap_wdata_d = trap_wdata_q;
    old_d        = old_q;
    ill_d        = ill_q;

    req_ready    = 1'b0;
    trap_ready   = 1'b0;
    csr_addr     = '0;
    csr_rd_en    = 1'b0;
    csr_wr_en    = 1'b0;
    csr_wdata    = '0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_illegal  = 1'b0;

    case (state_q)
      IDLE: begin
        // The trap unit wins a simultaneous request; the pipeline is held off that cycle
        trap_ready = 1'b1;
        req_ready  = !bus.trap_valid;
        if (bus.trap_valid) begin
          trap_addr_d  = bus.trap_addr;
          trap_wdata_d = bus.trap_wdata;
          state_d      = TRAP;
        end else if (bus.req_valid) begin
          op_d      = bus.req_op;
          imm_d     = bus.req_imm;
          addr_d    = bus.req_addr;
          rs1_d     = bus.req_rs1_value;
          zimm_d    = bus.req_zimm;
          rd_zero_d = bus.req_rd_zero;
          old_d     = '0;
          ill_d     = 1'b0;
          state_d   = READ;
        end
      end

      READ: begin
        csr_addr  = addr_q;
        csr_rd_en = !rd_suppress;
        old_d     = rd_suppress ? '0 : bus.csr_rdata;
        ill_d     = bus.csr_illegal | (op_q == OP_ILL);
        state_d   = WRITE;
      end

      WRITE: begin
        csr_addr = addr_q;
        if (write_allowed) begin
          csr_wr_en = 1'b1;
          csr_wdata = new_value;
        end
        ill_d   = ill_q | bus.csr_illegal | ro_violation;
        state_d = RESP;
      end

      RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = ill_q ? '0 : old_q;
        rsp_illegal = ill_q;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      TRAP: begin
        // Trap writes are unconditional; any rejection by the CSR file is not reported back
        csr_addr  = trap_addr_q;
        csr_wr_en = 1'b1;
        csr_wdata = trap_wdata_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-field registers; reset discards any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      imm_q        <= 1'b0;
      addr_q       <= '0;
      rs1_q        <= '0;
      zimm_q       <= '0;
      rd_zero_q    <= 1'b0;
      trap_addr_q  <= '0;
      trap_wdata_q <= '0;
      old_q        <= '0;
      ill_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      imm_q        <= imm_d;
      addr_q       <= addr_d;
      rs1_q        <= rs1_d;
      zimm_q       <= zimm_d;
      rd_zero_q    <= rd_zero_d;
      trap_addr_q  <= trap_addr_d;
      trap_wdata_q <= trap_wdata_d;
      old_q        <= old_d;
      ill_q        <= ill_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.trap_ready  = trap_ready;
  assign bus.csr_addr    = csr_addr;
  assign bus.csr_rd_en   = csr_rd_en;
  assign bus.csr_wr_en   = csr_wr_en;
  assign bus.csr_wdata   = csr_wdata;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_illegal = rsp_illegal;

endmodule

// File: doc/csr_access_sequencer.md
# csr_access_sequencer

Sequences every CSR access in the core and shares the CSR file between the instruction pipeline and the trap unit. It performs the read-modify-write for CSRRW/CSRRS/CSRRC (register and immediate forms) as separate read and write phases, applies the architectural write-suppression rules, and returns the old value or an illegal-instruction flag to the pipeline. It sits between decode/execute and the `csr` block and is the only master that drives CSR read and write enables.

## Interface
- `XLEN`, 32, data width; matches `arch_reg`.
- `clock`  in  1  core clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline CSR request.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_op`  in  2  funct3[1:0]: 01 RW, 10 RS, 11 RC; 00 is illegal.
- `req_imm`  in  1  funct3[2]; 1 selects `req_zimm` as source.
- `req_addr`  in  12  CSR address.
- `req_rs1_value`  in  XLEN  rs1 contents.
- `req_zimm`  in  5  immediate / rs1 index field.
- `req_rd_zero`  in  1  rd == x0.
- `trap_valid`  in  1  trap-unit write request (write-only).
- `trap_ready`  out  1  trap request accepted on handshake.
- `trap_addr`  in  12  CSR address for trap write.
- `trap_wdata`  in  XLEN  trap write data.
- `csr_addr`  out  12  address to CSR file.
- `csr_rd_en`  out  1  read strobe.
- `csr_rdata`  in  XLEN  CSR file read data, valid same cycle as `csr_rd_en`.
- `csr_illegal`  in  1  CSR file rejects address/privilege, valid with `csr_rd_en` or `csr_wr_en`.
- `csr_wr_en`  out  1  write strobe.
- `csr_wdata`  out  XLEN  write data.
- `rsp_valid`  out  1  response to pipeline.
- `rsp_ready`  in  1  pipeline consumes response.
- `rsp_rdata`  out  XLEN  old CSR value (for rd); 0 when illegal.
- `rsp_illegal`  out  1  raise illegal-instruction exception.

## Operation
- States: IDLE, READ, WRITE, RESP, TRAP.
- IDLE: `trap_ready = 1`; `req_ready = !trap_valid`. Trap has priority on simultaneous valids. Trap handshake -> TRAP; request handshake -> READ. All request fields registered at handshake.
- Source operand `src` = `req_imm ? {27'b0, req_zimm} : req_rs1_value`.
- READ: `csr_addr = addr_q`, `csr_rd_en = 1` unless op is RW and `req_rd_zero` (read side effects suppressed). Capture `old = csr_rdata` (0 if read suppressed) and `ill = csr_illegal | (op == 00)`. -> WRITE.
- WRITE: new value RW `src`, RS `old | src`, RC `old & ~src`. Write performed (`csr_wr_en = 1`) only if `!ill` and (op == RW or `src != 0`; for register form the test is `req_zimm != 0`, i.e. rs1 != x0). `csr_illegal` sampled during write ORs into `ill`. -> RESP.
- RESP: `rsp_valid = 1`, `rsp_rdata = ill ? 0 : old`, `rsp_illegal = ill`; held stable until `rsp_ready`, then -> IDLE.
- TRAP: `csr_addr = trap_addr_q`, `csr_wr_en = 1`, `csr_wdata = trap_wdata_q`; `csr_illegal` ignored. -> IDLE.
- `csr_rd_en` and `csr_wr_en` never asserted in the same cycle; all CSR-side outputs 0 outside READ/WRITE/TRAP.

## Timing
- Reset (async assert): state IDLE; `req_ready`, `trap_ready` follow IDLE rules combinationally; `csr_rd_en`, `csr_wr_en`, `rsp_valid`, `rsp_illegal` 0; `csr_addr`, `csr_wdata`, `rsp_rdata` 0. In-flight access discarded, no partial write. Deassertion is synchronised externally.
- Request latency: handshake at edge N; READ in cycle N+1, WRITE N+2, `rsp_valid` from N+3. Fixed regardless of suppression.
- Trap latency: handshake at N; write in cycle N+1; back in IDLE N+2.
- Back-to-back: new handshake possible in the cycle after RESP completes (IDLE cycle); throughput one request per 4 cycles with `rsp_ready` tied high.
- Trap arriving while a request is in flight waits in IDLE; request handshake blocked that IDLE cycle.

## Configuration
- `CSR_RO_CHECK_EN`: when defined, an access whose `req_addr[11:10] == 2'b11` that would write (per WRITE rules) sets `ill`, suppresses the write and returns `rsp_illegal = 1`; reads of such CSRs (RS/RC with zero source) remain legal. When undefined, read-only enforcement is left entirely to `csr_illegal` from the CSR file.

## Test plan
- CSRRS x5, 0xC00 (rs1=x0), `csr_rdata = 0x1234` -> read strobe once, no `csr_wr_en`, `rsp_rdata = 0x1234`, `rsp_illegal = 0`, `rsp_valid` 3 cycles after accept.
- CSRRC, rs1 value 0x0F, old 0xFF -> `csr_wdata = 0xF0` with `csr_wr_en` in WRITE; CSRRWI rd=x0, zimm=5 -> no `csr_rd_en`, write 0x5, `rsp_rdata = 0`.
- `trap_valid` and `req_valid` same cycle in IDLE -> trap written first (addr/data on bus one cycle later), request accepted two cycles after, completes normally.
- `csr_illegal = 1` during READ -> no write, `rsp_illegal = 1`, `rsp_rdata = 0`; `req_op = 00` -> same.
- `rsp_ready` low 5 cycles -> `rsp_valid`/data stable, `req_ready = 0`; `reset_n` pulsed in WRITE -> `csr_wr_en` drops immediately, state IDLE.
- With `CSR_RO_CHECK_EN`: CSRRW to 0xC01 -> `rsp_illegal = 1`, no write; CSRRS 0xC01 rs1=x0 -> legal. Without macro: same CSRRW writes unless `csr_illegal`.
